// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and constants for the program loader.
//               The CSUM state exists only when LOADER_CHECKSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    localparam int c_HDR_BYTES      = 2;
    localparam int c_BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR0 = 3'd1,
        S_HDR1 = 3'd2,
        S_DATA = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM = 3'd4,
`endif
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    // States in which the loader presents RX_READY to the host.
    function automatic logic f_accepts_bytes(input state_t s);
        logic r;
        r = (s == S_HDR0) || (s == S_HDR1) || (s == S_DATA) || (s == S_ERR);
`ifdef LOADER_CHECKSUM_EN
        r = r || (s == S_CSUM);
`endif
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_assembler.sv
`default_nettype none
// ============================================================================
// Module      : byte_assembler
// Description : Packs little-endian bytes into words; flags the word on the
//               cycle its last byte arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_assembler
    import loader_pkg::*;
(
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            clear_i,
    input  logic                            byte_valid_i,
    input  logic [7:0]                      byte_i,
    output logic                            word_valid_o,
    output logic [8*c_BYTES_PER_WORD-1:0]   word_o
);

    localparam int         c_WORD_W    = 8 * c_BYTES_PER_WORD;
    localparam logic [1:0] c_LAST_BYTE = 2'(c_BYTES_PER_WORD - 1);

    // Holds the earlier bytes of the word; the final byte is taken straight
    // from the input so the word is complete on its arrival cycle.
    logic [c_WORD_W-9:0] shift_q;
    logic [1:0]          cnt_q;

    assign word_valid_o = byte_valid_i && !clear_i && (cnt_q == c_LAST_BYTE);
    assign word_o       = {byte_i, shift_q};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clear_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (byte_valid_i) begin
            shift_q <= {byte_i, shift_q[c_WORD_W-9:8]};
            cnt_q   <= cnt_q + 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Loads a length-prefixed byte stream into instruction memory
//               while holding the core. Define LOADER_CHECKSUM_EN to require a
//               trailing XOR checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY,
    output logic              IMEM_WE,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    output logic [31:0]       IMEM_WDATA,
    output logic              CORE_HOLD,
    output logic              LOAD_DONE,
    output logic              ERROR
);

    localparam int                 c_CNT_W = ADDR_W + 1;
    localparam logic [31:0]        c_DEPTH = 32'(2 ** ADDR_W);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
    localparam state_t             c_TAIL  = S_CSUM;
`else
    localparam state_t             c_TAIL  = S_DONE;
`endif

    state_t              state_q, state_d;
    logic [7:0]          hdr_lo_q;
    logic [c_CNT_W-1:0]  n_q;
    logic [c_CNT_W-1:0]  idx_q;
    logic                rx_ready_q;
    logic                imem_we_q;
    logic [ADDR_W-1:0]   imem_addr_q;
    logic [31:0]         imem_wdata_q;
    logic                core_hold_q;
    logic                load_done_q;
    logic                error_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          csum_q;
`endif

    logic                       w_accept;
    logic                       w_asm_clear;
    logic                       w_asm_valid;
    logic                       w_word_valid;
    logic [31:0]                w_word;
    logic [8*c_HDR_BYTES-1:0]   w_hdr_len;

    assign w_accept    = RX_VALID && rx_ready_q;
    assign w_hdr_len   = {RX_DATA, hdr_lo_q};
    assign w_asm_clear = START || (state_q != S_DATA);
    assign w_asm_valid = w_accept && (state_q == S_DATA);

    byte_assembler u_byte_assembler (
        .clk_i        (CLK),
        .rst_i        (RST),
        .clear_i      (w_asm_clear),
        .byte_valid_i (w_asm_valid),
        .byte_i       (RX_DATA),
        .word_valid_o (w_word_valid),
        .word_o       (w_word)
    );

    always_comb begin
        state_d = state_q;
        if (START) begin
            state_d = S_HDR0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_HDR0: if (w_accept) state_d = S_HDR1;
                S_HDR1: begin
                    if (w_accept) begin
                        if (w_hdr_len == '0)
                            state_d = c_TAIL;
                        else if (32'(w_hdr_len) > c_DEPTH)
                            state_d = S_ERR;
                        else
                            state_d = S_DATA;
                    end
                end
                S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                    // Leave on the last byte so the checksum byte can follow
                    // back-to-back; the final write still issues next cycle.
                    if (w_word_valid && (idx_q == n_q - c_ONE))
                        state_d = S_CSUM;
`else
                    // Index reaches N in the cycle the final word is written.
                    if (idx_q == n_q)
                        state_d = S_DONE;
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: if (w_accept) state_d = (RX_DATA == csum_q) ? S_DONE : S_ERR;
`endif
                S_DONE: state_d = S_IDLE;
                S_ERR:  state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            hdr_lo_q     <= '0;
            n_q          <= '0;
            idx_q        <= '0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_hold_q  <= 1'b0;
            load_done_q  <= 1'b0;
            error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rx_ready_q  <= f_accepts_bytes(state_d);
            core_hold_q <= (state_d != S_IDLE) && (state_d != S_DONE);
            load_done_q <= (state_d == S_DONE);
            error_q     <= (state_d == S_ERR);
            imem_we_q   <= w_word_valid;
            if (w_word_valid) begin
                imem_addr_q  <= idx_q[ADDR_W-1:0];
                imem_wdata_q <= w_word;
            end
            if (START) begin
                idx_q <= '0;
                n_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum_q <= '0;
`endif
            end else begin
                if (w_word_valid)
                    idx_q <= idx_q + c_ONE;
                if (w_accept && (state_q == S_HDR0))
                    hdr_lo_q <= RX_DATA;
                if (w_accept && (state_q == S_HDR1))
                    n_q <= c_CNT_W'(w_hdr_len);
`ifdef LOADER_CHECKSUM_EN
                if (w_accept && ((state_q == S_HDR0) || (state_q == S_HDR1) || (state_q == S_DATA)))
                    csum_q <= csum_q ^ RX_DATA;
`endif
            end
        end
    end

    assign RX_READY   = rx_ready_q;
    assign IMEM_WE    = imem_we_q;
    assign IMEM_ADDR  = imem_addr_q;
    assign IMEM_WDATA = imem_wdata_q;
    assign CORE_HOLD  = core_hold_q;
    assign LOAD_DONE  = load_done_q;
    assign ERROR      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Directed self-checking bench for program_loader (ADDR_W=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int ADDR_W = 2;

    logic              CLK;
    logic              RST;
    logic              START;
    logic [7:0]        RX_DATA;
    logic              RX_VALID;
    logic              RX_READY;
    logic              IMEM_WE;
    logic [ADDR_W-1:0] IMEM_ADDR;
    logic [31:0]       IMEM_WDATA;
    logic              CORE_HOLD;
    logic              LOAD_DONE;
    logic              ERROR;

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;
    int nw       = 0;
    int nd       = 0;
    int done_cyc = 0;
    int last_cyc = 0;
    logic [ADDR_W-1:0] wa [16];
    logic [31:0]       wd [16];
    int                wc [16];
    logic [7:0]        xacc;

    program_loader #(.ADDR_W(ADDR_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .RX_DATA    (RX_DATA),
        .RX_VALID   (RX_VALID),
        .RX_READY   (RX_READY),
        .IMEM_WE    (IMEM_WE),
        .IMEM_ADDR  (IMEM_ADDR),
        .IMEM_WDATA (IMEM_WDATA),
        .CORE_HOLD  (CORE_HOLD),
        .LOAD_DONE  (LOAD_DONE),
        .ERROR      (ERROR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
        cycle++;
        if (IMEM_WE) begin
            if (nw < 16) begin
                wa[nw] = IMEM_ADDR;
                wd[nw] = IMEM_WDATA;
                wc[nw] = cycle;
            end
            nw++;
        end
        if (LOAD_DONE) begin
            nd++;
            done_cyc = cycle;
        end
    endtask

    task automatic send(input logic [7:0] b);
        check("rx_ready", 32'(RX_READY), 32'd1);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        xacc     = xacc ^ b;
        cyc();
    endtask

    task automatic gap(input int n);
        RX_VALID = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic clear_log();
        nw = 0;
        nd = 0;
    endtask

    task automatic start_load();
        START    = 1'b1;
        RX_VALID = 1'b0;
        cyc();
        START    = 1'b0;
        xacc     = 8'h00;
    endtask

    task automatic send_csum();
`ifdef LOADER_CHECKSUM_EN
        send(xacc);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"},   32'(RX_READY),   32'd0);
        check({tag, "_we"},    32'(IMEM_WE),    32'd0);
        check({tag, "_addr"},  32'(IMEM_ADDR),  32'd0);
        check({tag, "_wdata"}, IMEM_WDATA,      32'd0);
        check({tag, "_hold"},  32'(CORE_HOLD),  32'd0);
        check({tag, "_done"},  32'(LOAD_DONE),  32'd0);
        check({tag, "_err"},   32'(ERROR),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; START = 1'b0; RX_VALID = 1'b0; RX_DATA = 8'h00; xacc = 8'h00;
        cyc(); cyc();
        check_reset_outputs("rst");
        RST = 1'b0;
        cyc();

        // Two-word load, no gaps
        clear_log();
        start_load();
        check("a_hold_on", 32'(CORE_HOLD), 32'd1);
        check("a_err_clr", 32'(ERROR), 32'd0);
        send(8'h02); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        send_csum();
        gap(4);
        check("a_nwrites", 32'(nw), 32'd2);
        check("a_addr0", 32'(wa[0]), 32'd0);
        check("a_data0", wd[0], 32'h12345678);
        check("a_addr1", 32'(wa[1]), 32'd1);
        check("a_data1", wd[1], 32'hDEADBEEF);
        check("a_ndone", 32'(nd), 32'd1);
        check("a_done_lat", 32'(done_cyc - wc[1]), 32'd1);
        check("a_hold_off", 32'(CORE_HOLD), 32'd0);
        check("a_rdy_idle", 32'(RX_READY), 32'd0);

        // Empty program
        clear_log();
        start_load();
        send(8'h00); send(8'h00);
        send_csum();
        last_cyc = cycle;
        gap(3);
        check("b_nwrites", 32'(nw), 32'd0);
        check("b_ndone", 32'(nd), 32'd1);
        check("b_done_within2", 32'((done_cyc >= last_cyc) && (done_cyc - last_cyc <= 2)), 32'd1);

        // Oversize header (N=5 > DEPTH=4) and drain
        clear_log();
        start_load();
        send(8'h05); send(8'h00);
        check("c_err_set", 32'(ERROR), 32'd1);
        check("c_hold", 32'(CORE_HOLD), 32'd1);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        gap(2);
        check("c_err_sticky", 32'(ERROR), 32'd1);
        check("c_nwrites", 32'(nw), 32'd0);
        check("c_ndone", 32'(nd), 32'd0);
        start_load();
        check("c_err_cleared", 32'(ERROR), 32'd0);

        // N = DEPTH boundary
        clear_log();
        start_load();
        send(8'h04); send(8'h00);
        for (int w = 0; w < 4; w++)
            for (int k = 0; k < 4; k++)
                send(8'(16 * w + k));
        send_csum();
        gap(3);
        check("d_nwrites", 32'(nw), 32'd4);
        for (int w = 0; w < 4; w++) begin
            check("d_addr", 32'(wa[w]), 32'(w));
            check("d_data", wd[w], 32'h03020100 + 32'h10101010 * 32'(w));
        end
        check("d_ndone", 32'(nd), 32'd1);
        check("d_err", 32'(ERROR), 32'd0);

        // RX_VALID toggling every cycle
        clear_log();
        start_load();
        send(8'h01); send(8'h00);
        send(8'h11); gap(1);
        send(8'h22); gap(1);
        send(8'h33); gap(1);
        send(8'h44); gap(1);
        send_csum();
        gap(3);
        check("e_nwrites", 32'(nw), 32'd1);
        check("e_addr0", 32'(wa[0]), 32'd0);
        check("e_data0", wd[0], 32'h44332211);
        check("e_ndone", 32'(nd), 32'd1);

        // Reset mid-word
        clear_log();
        start_load();
        send(8'h02); send(8'h00); send(8'h01); send(8'h02);
        RX_VALID = 1'b0;
        RST = 1'b1;
        #1;
        check_reset_outputs("f_async");
        cyc(); cyc();
        RST = 1'b0;
        cyc();
        check("f_nwrites", 32'(nw), 32'd0);
        clear_log();
        start_load();
        send(8'h01); send(8'h00);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        send_csum();
        gap(3);
        check("f_nwrites2", 32'(nw), 32'd1);
        check("f_addr0", 32'(wa[0]), 32'd0);
        check("f_data0", wd[0], 32'hDDCCBBAA);
        check("f_ndone", 32'(nd), 32'd1);

        // Abort mid-load; START with a simultaneous byte discards it
        clear_log();
        start_load();
        send(8'h02); send(8'h00);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h05); send(8'h06);
        START = 1'b1; RX_DATA = 8'h07; RX_VALID = 1'b1;
        cyc();
        START = 1'b0; xacc = 8'h00;
        check("g_hold", 32'(CORE_HOLD), 32'd1);
        send(8'h01); send(8'h00);
        send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
        send_csum();
        gap(3);
        check("g_nwrites", 32'(nw), 32'd2);
        check("g_addr0", 32'(wa[0]), 32'd0);
        check("g_data0", wd[0], 32'h04030201);
        check("g_addr1", 32'(wa[1]), 32'd0);
        check("g_data1", wd[1], 32'hA4A3A2A1);
        check("g_ndone", 32'(nd), 32'd1);
        check("g_err", 32'(ERROR), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Explicit checksum match and mismatch
        clear_log();
        start_load();
        send(8'h01); send(8'h00);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        send(8'h01);
        gap(2);
        check("h_ndone", 32'(nd), 32'd1);
        check("h_err", 32'(ERROR), 32'd0);
        check("h_data0", wd[0], 32'hDDCCBBAA);
        clear_log();
        start_load();
        send(8'h01); send(8'h00);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        send(8'h00);
        gap(2);
        check("h_bad_ndone", 32'(nd), 32'd0);
        check("h_bad_err", 32'(ERROR), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
